mcdf_prio_arb: RTL and testbench

MCDF_PRIO_ARB -- requirements
Module: mcdf_prio_arb

---
 rtl/mcdf_arb_pkg.sv | 19 +
 rtl/mcdf_prio_sel.sv | 62 ++++++
 rtl/mcdf_prio_arb.sv | 130 +++++++++++++
 tb/tb_mcdf_prio_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcdf_arb_pkg.sv
`default_nettype none
// ============================================================================
// mcdf_arb_pkg : shared FSM state type and default parameters for the arbiter
// Revision     : 1.0
// ============================================================================
package mcdf_arb_pkg;

    localparam int unsigned c_def_num_ch = 3;
    localparam int unsigned c_def_prio_w = 2;
    localparam int unsigned c_def_len_w  = 8;
    localparam int unsigned c_def_rr_en  = 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage : mcdf_arb_pkg
`default_nettype wire

// File: rtl/mcdf_prio_sel.sv
`default_nettype none
// ============================================================================
// mcdf_prio_sel : combinational winner select, lowest priority value wins,
//                 ties broken round-robin from i_rr_ptr or by lowest index
// Revision      : 1.0
// ============================================================================
module mcdf_prio_sel
    import mcdf_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = c_def_num_ch,
    parameter int unsigned PRIO_W = c_def_prio_w,
    parameter int unsigned RR_EN  = c_def_rr_en,
    localparam int unsigned IDX_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]        i_req,
    input  logic [NUM_CH*PRIO_W-1:0] i_prio,
    input  logic [IDX_W-1:0]         i_rr_ptr,
    output logic [IDX_W-1:0]         o_winner,
    output logic                     o_valid
);

    logic [PRIO_W-1:0] w_min;
    logic              w_found;
    logic [NUM_CH-1:0] w_tie;
    logic [IDX_W-1:0]  w_base;
    int                w_dist;
    int                w_best;

    always_comb begin
        w_min    = '1;
        w_found  = 1'b0;
        w_tie    = '0;
        w_base   = (RR_EN != 0) ? i_rr_ptr : '0;
        w_dist   = 0;
        w_best   = int'(NUM_CH);
        o_winner = '0;

        for (int k = 0; k < NUM_CH; k++) begin
            if (i_req[k] && (!w_found || (i_prio[k*PRIO_W +: PRIO_W] < w_min))) begin
                w_min   = i_prio[k*PRIO_W +: PRIO_W];
                w_found = 1'b1;
            end
        end

        // Among the tied channels, the one closest upward from the base wins.
        for (int k = 0; k < NUM_CH; k++) begin
            w_tie[k] = i_req[k] && (i_prio[k*PRIO_W +: PRIO_W] == w_min);
            w_dist   = k - int'(w_base);
            if (w_dist < 0) begin
                w_dist = w_dist + int'(NUM_CH);
            end
            if (w_tie[k] && (w_dist < w_best)) begin
                w_best   = w_dist;
                o_winner = IDX_W'(k);
            end
        end

        o_valid = w_found;
    end

endmodule : mcdf_prio_sel
`default_nettype wire

// File: rtl/mcdf_prio_arb.sv
`default_nettype none
// ============================================================================
// mcdf_prio_arb : priority arbiter granting whole multi-beat packets
// Revision      : 1.0
// ============================================================================
module mcdf_prio_arb
    import mcdf_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = c_def_num_ch,
    parameter int unsigned PRIO_W = c_def_prio_w,
    parameter int unsigned LEN_W  = c_def_len_w,
    parameter int unsigned RR_EN  = c_def_rr_en
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NUM_CH-1:0]          req_i,
    input  logic [NUM_CH*PRIO_W-1:0]   prio_i,
    input  logic [NUM_CH*LEN_W-1:0]    len_i,
    input  logic                       beat_i,
    output logic [NUM_CH-1:0]          gnt_o,
    output logic [$clog2(NUM_CH)-1:0]  gnt_idx_o,
    output logic                       gnt_vld_o
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [NUM_CH-1:0] r_gnt;
    logic [NUM_CH-1:0] w_gnt_nxt;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  w_rr_nxt;
    logic [IDX_W-1:0]  w_idx_wrap;

    logic [IDX_W-1:0]  w_sel_idx;
    logic              w_sel_vld;
    logic [LEN_W-1:0]  w_sel_len;
    logic [NUM_CH-1:0] w_sel_onehot;

    mcdf_prio_sel #(
        .NUM_CH (NUM_CH),
        .PRIO_W (PRIO_W),
        .RR_EN  (RR_EN)
    ) u_sel (
        .i_req    (req_i),
        .i_prio   (prio_i),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_sel_idx),
        .o_valid  (w_sel_vld)
    );

    always_comb begin
        w_sel_len    = '0;
        w_sel_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sel_onehot[k] = (w_sel_idx == IDX_W'(k));
            if (w_sel_idx == IDX_W'(k)) begin
                w_sel_len = len_i[k*LEN_W +: LEN_W];
            end
        end
    end

    // With lowest-index tie-break the pointer is never advanced and stays zero.
    if (RR_EN != 0) begin : g_rr_on
        assign w_idx_wrap = (r_gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : r_gnt_idx + IDX_W'(1);
    end else begin : g_rr_off
        assign w_idx_wrap = '0;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_gnt_idx;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_ptr;

        case (r_state)
            ST_IDLE: begin
                if (w_sel_vld) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = w_sel_onehot;
                    w_idx_nxt   = w_sel_idx;
                    w_cnt_nxt   = (w_sel_len == '0) ? LEN_W'(1) : w_sel_len;
                end
            end
            ST_GRANT: begin
                if (beat_i) begin
                    if (r_cnt <= LEN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_rr_nxt    = w_idx_wrap;
                    end else begin
                        w_cnt_nxt   = r_cnt - LEN_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_cnt     <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rr_ptr  <= w_rr_nxt;
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_idx_o = r_gnt_idx;
    assign gnt_vld_o = (r_state == ST_GRANT);

endmodule : mcdf_prio_arb
`default_nettype wire

// File: tb/tb_mcdf_prio_arb.sv
`default_nettype none
// ============================================================================
// tb_mcdf_prio_arb : directed bench with scoreboard for round-robin and
//                    lowest-index arbiter instances
// Revision         : 1.0
// ============================================================================
module tb_mcdf_prio_arb;

    typedef struct {
        int idx;
        int beats;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [2:0]  req_a;
    logic [2:0]  req_b;
    logic [5:0]  prio;
    logic [23:0] len;
    logic        beat_a;
    logic        beat_b;
    logic [2:0]  gnt_a;
    logic [2:0]  gnt_b;
    logic [1:0]  idx_a;
    logic [1:0]  idx_b;
    logic        vld_a;
    logic        vld_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    mcdf_prio_arb #(.NUM_CH(3), .PRIO_W(2), .LEN_W(8), .RR_EN(1)) dut_a (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .req_i     (req_a),
        .prio_i    (prio),
        .len_i     (len),
        .beat_i    (beat_a),
        .gnt_o     (gnt_a),
        .gnt_idx_o (idx_a),
        .gnt_vld_o (vld_a)
    );

    mcdf_prio_arb #(.NUM_CH(3), .PRIO_W(2), .LEN_W(8), .RR_EN(0)) dut_b (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .req_i     (req_b),
        .prio_i    (prio),
        .len_i     (len),
        .beat_i    (beat_b),
        .gnt_o     (gnt_b),
        .gnt_idx_o (idx_b),
        .gnt_vld_o (vld_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [5:0] pk_p(input int p0, input int p1, input int p2);
        return {2'(p2), 2'(p1), 2'(p0)};
    endfunction

    function automatic logic [23:0] pk_l(input int l0, input int l1, input int l2);
        return {8'(l2), 8'(l1), 8'(l0)};
    endfunction

    function automatic int vld(input bit b);
        return b ? int'(vld_b) : int'(vld_a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit b, input logic [2:0] v);
        if (b) req_b = v;
        else   req_a = v;
    endtask

    task automatic set_beat(input bit b, input logic v);
        if (b) beat_b = v;
        else   beat_a = v;
    endtask

    // One packet: request, expect grant next cycle, then nb beats with gap idle cycles before each.
    task automatic pkt(input bit b, input logic [2:0] rq, input logic [5:0] pr,
                       input logic [23:0] ln, input int ei, input int nb, input int gap);
        set_req(b, rq);
        prio = pr;
        len  = ln;
        if (b) q_b.push_back('{idx: ei, beats: nb});
        else   q_a.push_back('{idx: ei, beats: nb});
        tick();
        check("grant_latency", vld(b), 1);
        for (int i = 0; i < nb; i++) begin
            for (int g = 0; g < gap; g++) begin
                set_beat(b, 1'b0);
                tick();
            end
            set_beat(b, 1'b1);
            tick();
        end
        set_beat(b, 1'b0);
        check("grant_release", vld(b), 0);
    endtask

    // Scoreboard monitors: pop on each grant, count beats until it drops.
    bit   pv_a = 1'b0;
    bit   pv_b = 1'b0;
    int   nb_a = 0;
    int   nb_b = 0;
    exp_t e_a  = '{idx: 0, beats: 0};
    exp_t e_b  = '{idx: 0, beats: 0};

    always @(negedge clk) begin
        if (vld_a === 1'b1 && !pv_a) begin
            check("grant_a_queued", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e_a = q_a.pop_front();
                check("gnt_idx_a", int'(idx_a), e_a.idx);
                check("gnt_onehot_a", int'(gnt_a), 1 << e_a.idx);
            end
            nb_a = 0;
        end
        if (vld_a === 1'b1 && beat_a) nb_a++;
        if (vld_a !== 1'b1 && pv_a) check("beats_a", nb_a, e_a.beats);
        pv_a = (vld_a === 1'b1);
    end

    always @(negedge clk) begin
        if (vld_b === 1'b1 && !pv_b) begin
            check("grant_b_queued", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e_b = q_b.pop_front();
                check("gnt_idx_b", int'(idx_b), e_b.idx);
                check("gnt_onehot_b", int'(gnt_b), 1 << e_b.idx);
            end
            nb_b = 0;
        end
        if (vld_b === 1'b1 && beat_b) nb_b++;
        if (vld_b !== 1'b1 && pv_b) check("beats_b", nb_b, e_b.beats);
        pv_b = (vld_b === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn   = 1'b0;
        req_a  = '0;
        req_b  = '0;
        prio   = '0;
        len    = '0;
        beat_a = 1'b0;
        beat_b = 1'b0;
        repeat (3) tick();
        check("rst_gnt_a", int'(gnt_a), 0);
        check("rst_idx_a", int'(idx_a), 0);
        check("rst_vld_a", int'(vld_a), 0);
        check("rst_vld_b", int'(vld_b), 0);
        rstn = 1'b1;
        repeat (2) tick();
        check("idle_no_req_vld", int'(vld_a), 0);
        check("idle_no_req_gnt", int'(gnt_a), 0);

        // Ties {1,1,3}: pointer 0 gives ch0, then ch1.
        pkt(0, 3'b111, pk_p(1, 1, 3), pk_l(1, 1, 1), 0, 1, 0);
        pkt(0, 3'b111, pk_p(1, 1, 3), pk_l(1, 1, 1), 1, 1, 0);
        req_a = '0;
        tick();

        // Reset in the middle of a 4-beat packet to ch2 (after one beat).
        req_a = 3'b100;
        len   = pk_l(4, 4, 4);
        q_a.push_back('{idx: 2, beats: 1});
        tick();
        check("midpkt_vld", int'(vld_a), 1);
        beat_a = 1'b1;
        tick();
        beat_a = 1'b0;
        check("midpkt_cnt3_vld", int'(vld_a), 1);
        rstn = 1'b0;
        #1;
        check("async_rst_vld", int'(vld_a), 0);
        check("async_rst_gnt", int'(gnt_a), 0);
        check("async_rst_idx", int'(idx_a), 0);
        req_a = '0;
        tick();
        rstn = 1'b1;
        tick();

        // Equal priorities rotate from a fresh pointer: ch0, ch1, ch2, ch0.
        for (int i = 0; i < 4; i++) begin
            pkt(0, 3'b111, pk_p(2, 2, 2), pk_l(2, 2, 2), i % 3, 2, i % 2);
        end
        req_a = '0;
        tick();

        // Distinct priorities {3,1,2}: ch1 for two beats.
        pkt(0, 3'b111, pk_p(3, 1, 2), pk_l(2, 2, 2), 1, 2, 0);
        req_a = '0;
        tick();

        // Atomic packet: ch2 len 4, inputs change mid-grant, beat gaps.
        req_a = 3'b100;
        prio  = pk_p(3, 3, 1);
        len   = pk_l(1, 1, 4);
        q_a.push_back('{idx: 2, beats: 4});
        tick();
        check("atomic_start_idx", int'(idx_a), 2);
        req_a = 3'b001;
        prio  = pk_p(0, 3, 1);
        len   = pk_l(1, 1, 1);
        q_a.push_back('{idx: 0, beats: 1});
        beat_a = 1'b1; tick();
        beat_a = 1'b0; tick(); tick();
        beat_a = 1'b1; tick(); tick();
        beat_a = 1'b0; tick();
        check("atomic_held_vld", int'(vld_a), 1);
        check("atomic_held_idx", int'(idx_a), 2);
        beat_a = 1'b1; tick();
        beat_a = 1'b0;
        check("atomic_idle_gap", int'(vld_a), 0);
        tick();
        check("atomic_next_vld", int'(vld_a), 1);
        check("atomic_next_idx", int'(idx_a), 0);
        beat_a = 1'b1; tick();
        beat_a = 1'b0;
        check("atomic_next_done", int'(vld_a), 0);
        req_a = '0;
        tick();

        // Beats while idle do nothing; len 0 behaves as one beat.
        beat_a = 1'b1;
        repeat (2) tick();
        beat_a = 1'b0;
        check("idle_beat_vld", int'(vld_a), 0);
        pkt(0, 3'b010, pk_p(3, 3, 3), pk_l(5, 0, 5), 1, 1, 0);
        req_a = '0;
        tick();

        // Lowest-index tie-break instance: ch0 every time.
        pkt(1, 3'b111, pk_p(1, 1, 3), pk_l(1, 1, 1), 0, 1, 0);
        pkt(1, 3'b111, pk_p(1, 1, 3), pk_l(1, 1, 1), 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            pkt(1, 3'b111, pk_p(2, 2, 2), pk_l(1, 1, 1), 0, 1, 0);
        end
        req_b = '0;
        repeat (3) tick();

        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mcdf_prio_arb
`default_nettype wire
